decompress: RTL
===============

DECOMPRESS -- requirements
Module: decompress

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_icoeffs  input  64  four d-bit compressed coefficients, lane k in bits [16k+15:16k], lane 0 = lowest coefficient index.
- i_icoeffs_valid  input  1  upstream word valid.
- o_icoeffs_ready  output  1  block accepts i_icoeffs this cycle.
- i_d  input  4  compression width d; legal values 1, 4, 5, 10, 11, 12.
- o_coeffs  output  64  four decompressed coefficients in the same lane order; bits [16k+15:16k+12] = 0.
- o_coeffs_valid  output  1  o_coeffs valid.
- i_coeffs_ready  input  1  downstream accepts o_coeffs.
- o_done  output  1  one-cycle pulse after the 64th output word of a polynomial.
REQ-002 SHALL have one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL compute per lane y = (3329*x + 2^(d-1)) >> d, where x = lane[d-1:0] and upper lane bits are ignored.
REQ-004 SHALL use a product/sum path of at least 23 bits; the result is always < 3329 and fits in 12 bits.
REQ-005 SHALL pass x = lane[11:0] through unchanged for d=12 and for any illegal d value.
REQ-006 SHALL process one polynomial as 256 coefficients = 64 input words and 64 output words.
REQ-007 SHALL use a two-stage pipeline: stage 1 registers the lane products plus the rounding constant; stage 2 registers the shifted results onto o_coeffs.
REQ-008 SHALL define the pipeline enable as en = !o_coeffs_valid || i_coeffs_ready; both stages advance only when en=1.
REQ-009 SHALL give a latency of 2 cycles from input handshake to o_coeffs_valid when no stall occurs; sustained throughput SHALL be 1 word/cycle.
REQ-010 SHALL hold o_coeffs and o_coeffs_valid stable while o_coeffs_valid=1 and i_coeffs_ready=0.
REQ-011 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-012 IDLE: o_icoeffs_ready = en; on an input handshake, latch i_d into d_reg, compute that word with i_d directly, and go to RUN.
REQ-013 RUN: o_icoeffs_ready = en; compute with d_reg; when the 64th input handshake occurs, go to DRAIN.
REQ-014 DRAIN: o_icoeffs_ready = 0; when the 64th output handshake occurs, go to DONE.
REQ-015 DONE: o_done = 1 for exactly one cycle, o_icoeffs_ready = 0, clear both counters, go to IDLE.
REQ-016 SHALL ignore changes on i_d after the first accepted word of a polynomial until the next IDLE.
REQ-017 SHALL keep a 7-bit input-handshake counter and a 7-bit output-handshake counter; neither increments on a cycle without a handshake.
REQ-018 Boundary: if the 64th output handshake and a new input word arrive in the same cycle, the new word SHALL NOT be accepted, since ready=0 in DRAIN.
REQ-019 Boundary: a bubble (i_icoeffs_valid=0) SHALL propagate as an invalid stage with no counter change.
REQ-020 Stage valid bits SHALL be cleared only by reset or by advancing with no incoming valid.

Reset
REQ-021 While i_rst=1 at a clock edge, the block SHALL set: FSM to IDLE, both counters to 0, stage valids to 0, o_coeffs=0, o_coeffs_valid=0, o_done=0, d_reg=0.
REQ-022 While i_rst=1, o_icoeffs_ready SHALL be 0.
REQ-023 Reset mid-polynomial SHALL discard all in-flight words; the next accepted word starts a new polynomial.

Verification
REQ-024 d=1, lanes x={1,0,1,0}, downstream ready=1 -> two cycles later o_coeffs lanes = {1665,0,1665,0}.
REQ-025 d=4, x=15 in all lanes -> 3121 in all lanes; d=10, x=1023 -> 3326; d=11, x=1 -> 2; d=5, x=16 -> 1665.
REQ-026 64 back-to-back words with d=10 and ready held at 1 -> 64 consecutive valid outputs, then o_done high for 1 cycle, 1 cycle after the last output handshake.
REQ-027 i_coeffs_ready toggling randomly -> no lost or duplicated words, outputs stable during stall, exactly 64 outputs, then o_done.
REQ-028 i_d changed from 4 to 11 at word 10 -> all 64 outputs computed with d=4; the next polynomial uses 11.
REQ-029 i_rst asserted at word 30, then a fresh 64-word polynomial -> no residual outputs, exactly 64 outputs, one o_done pulse.

Source files
------------

// File: rtl/decompress.sv
// Decompresses four d-bit coefficients per word to 12-bit values: y = (3329*x + 2^(d-1)) >> d.
// Two-stage stall-able pipeline with a polynomial-level FSM (64 words in, 64 words out, done pulse).
module decompress (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_icoeffs,
  input  logic        i_icoeffs_valid,
  output logic        o_icoeffs_ready,
  input  logic [3:0]  i_d,
  output logic [63:0] o_coeffs,
  output logic        o_coeffs_valid,
  input  logic        i_coeffs_ready,
  output logic        o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_d;
  logic [6:0]  r_in_cnt, r_out_cnt;
  logic        r_s1_valid;
  logic [22:0] r_s1_sum [4];
  logic [3:0]  r_s1_shift;

  logic        w_en, w_in_hs, w_out_hs, w_pass;
  logic [3:0]  w_d;
  logic [15:0] w_mask;
  logic [22:0] w_round;
  logic [15:0] w_lane [4];
  logic [22:0] w_sum  [4];
  logic [11:0] w_y    [4];

  assign w_en            = !o_coeffs_valid || i_coeffs_ready;
  assign o_icoeffs_ready = !i_rst && (r_state == S_IDLE || r_state == S_RUN) && w_en;
  assign w_in_hs         = i_icoeffs_valid && o_icoeffs_ready;
  assign w_out_hs        = o_coeffs_valid && i_coeffs_ready;
  assign o_done          = (r_state == S_DONE);
  // The first word of a polynomial is computed with i_d before it lands in r_d.
  assign w_d             = (r_state == S_IDLE) ? i_d : r_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_in_hs) w_next = S_RUN;
      S_RUN:   if (w_in_hs && r_in_cnt == 7'd63) w_next = S_DRAIN;
      S_DRAIN: if (w_out_hs && r_out_cnt == 7'd63) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pass = 1'b1;
    case (w_d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11: w_pass = 1'b0;
      default:                        w_pass = 1'b1;
    endcase
    w_mask  = w_pass ? 16'h0FFF : (16'd1 << w_d) - 16'd1;
    w_round = w_pass ? 23'd0 : (23'd1 << (w_d - 4'd1));
    for (int k = 0; k < 4; k++) begin
      w_lane[k] = i_icoeffs[16*k +: 16] & w_mask;
      w_sum[k]  = w_pass ? {7'd0, w_lane[k]} : ({7'd0, w_lane[k]} * 23'd3329) + w_round;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) w_y[k] = 12'(r_s1_sum[k] >> r_s1_shift);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_d            <= 4'd0;
      r_in_cnt       <= 7'd0;
      r_out_cnt      <= 7'd0;
      r_s1_valid     <= 1'b0;
      o_coeffs_valid <= 1'b0;
      o_coeffs       <= 64'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_in_hs) r_d <= i_d;
      if (r_state == S_DONE) begin
        r_in_cnt  <= 7'd0;
        r_out_cnt <= 7'd0;
      end else begin
        if (w_in_hs)  r_in_cnt  <= r_in_cnt + 7'd1;
        if (w_out_hs) r_out_cnt <= r_out_cnt + 7'd1;
      end
      if (w_en) begin
        r_s1_valid     <= w_in_hs;
        o_coeffs_valid <= r_s1_valid;
        if (r_s1_valid) begin
          for (int k = 0; k < 4; k++) o_coeffs[16*k +: 16] <= {4'd0, w_y[k]};
        end
      end
    end
  end

  // NOTE: stage-1 data is qualified by r_s1_valid, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_en && w_in_hs) begin
      r_s1_shift <= w_pass ? 4'd0 : w_d;
      for (int k = 0; k < 4; k++) r_s1_sum[k] <= w_sum[k];
    end
  end

endmodule
